// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU definitions: opcode encoding and default data width.
// Imported by the ALU and by every block that drives it.
package alu_mul_seq_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_OR  = 3'd1,
        ALU_SL  = 3'd2,
        ALU_SRL = 3'd3,
        ALU_SUB = 3'd4,
        ALU_SLT = 3'd5,
        ALU_AND = 3'd6,
        ALU_XOR = 3'd7
    } alu_op_e;

endpackage

// File: rtl/alu_mul_seq_alu.sv
// Shared combinational ALU of the data path.
// Flags: zero/msb describe in1, carry is meaningful for ADD only.
module alu_mul_seq_alu
    import alu_mul_seq_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic [WIDTH-1:0] alu_in1,
    input  logic [WIDTH-1:0] alu_in2,
    input  logic [2:0]       alu_control,
    output logic [WIDTH-1:0] alu_out,
    output logic             alu_zero,
    output logic             alu_msb,
    output logic             alu_carry
);

    localparam int SW = $clog2(WIDTH);

    logic [WIDTH:0]   w_sum;
    logic [SW-1:0]    w_sh;
    logic             w_lt;

    assign w_sum     = {1'b0, alu_in1} + {1'b0, alu_in2};
    assign w_sh      = alu_in2[SW-1:0];
    assign w_lt      = $signed(alu_in1) < $signed(alu_in2);
    assign alu_zero  = (alu_in1 == '0);
    assign alu_msb   = alu_in1[WIDTH-1];

    // Result mux and carry flag, selected by opcode
    always_comb begin
        alu_out   = '0;
        alu_carry = 1'b0;
        unique case (alu_op_e'(alu_control))
            ALU_ADD: begin
                alu_out   = w_sum[WIDTH-1:0];
                alu_carry = w_sum[WIDTH];
            end
            ALU_OR:  alu_out = alu_in1 | alu_in2;
            ALU_SL:  alu_out = alu_in1 << w_sh;
            ALU_SRL: alu_out = alu_in1 >> w_sh;
            ALU_SUB: alu_out = alu_in1 - alu_in2;
            ALU_SLT: alu_out = {{(WIDTH-1){1'b0}}, w_lt};
            ALU_AND: alu_out = alu_in1 & alu_in2;
            ALU_XOR: alu_out = alu_in1 ^ alu_in2;
            default: alu_out = '0;
        endcase
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiply sequencer borrowing the shared ALU.
// Owns the ALU inputs while busy; product is the low word plus overflow.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int WIDTH      = ALU_W,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             ovf,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_msb,
    input  logic             alu_carry
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ADD   = 3'd2,
        S_SHQ   = 3'd3,
        S_SHM   = 3'd4,
        S_FIN   = 3'd5,
        S_DONE  = 3'd6
    } seq_state_e;

    seq_state_e       r_state;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_product;
    logic             r_ovf;
    logic             w_stop;
    logic             w_mplier_nz;

    assign w_stop      = (EARLY_TERM && alu_zero) || (r_cnt == CNT_MAX);
    assign w_mplier_nz = |r_mplier;

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;
    assign ovf     = r_ovf;

    // Sequencer state with registered busy/done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_CHECK;
                        r_busy  <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (w_stop)
                        r_state <= S_FIN;
                    else if (alu_out[0])
                        r_state <= S_ADD;
                    else
                        r_state <= S_SHQ;
                end
                S_ADD: r_state <= S_SHQ;
                S_SHQ: r_state <= S_SHM;
                S_SHM: r_state <= S_CHECK;
                S_FIN: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Operand, accumulator and result registers fed from the ALU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_ovf     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= opa;
                        r_mplier <= opb;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_ovf    <= 1'b0;
                    end
                end
                S_ADD: begin
                    r_acc <= alu_out;
                    r_ovf <= r_ovf | alu_carry;
                end
                S_SHQ: r_mplier <= alu_out;
                S_SHM: begin
                    r_mcand <= alu_out;
                    r_ovf   <= r_ovf | (alu_msb & w_mplier_nz);
                    r_cnt   <= r_cnt + CW'(1);
                end
                S_FIN: r_product <= r_acc;
                default: ;
            endcase
        end
    end

    // ALU operand and opcode selection per state
    always_comb begin
        alu_in1     = '0;
        alu_in2     = '0;
        alu_control = ALU_ADD;
        unique case (r_state)
            S_CHECK: begin
                alu_in1     = r_mplier;
                alu_in2     = ONE;
                alu_control = ALU_AND;
            end
            S_ADD: begin
                alu_in1     = r_acc;
                alu_in2     = r_mcand;
                alu_control = ALU_ADD;
            end
            S_SHQ: begin
                alu_in1     = r_mplier;
                alu_in2     = ONE;
                alu_control = ALU_SRL;
            end
            S_SHM: begin
                alu_in1     = r_mcand;
                alu_in2     = ONE;
                alu_control = ALU_SL;
            end
            default: ;
        endcase
    end

endmodule
